// File: rtl/sa_ram_fifo_ctrl_64x64.sv
// FIFO controller wrapping an external two-port RAM with a registered read port.
// A 2-entry output buffer hides the one-cycle RAM read latency so pops can run at one word per cycle.
module sa_ram_fifo_ctrl_64x64 #(
    parameter int DW    = 64,
    parameter int AW    = 6,
    parameter int DEPTH = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_pvld,
    output logic            wr_prdy,
    input  logic [DW-1:0]   wr_pd,
    output logic            rd_pvld,
    input  logic            rd_prdy,
    output logic [DW-1:0]   rd_pd,
    output logic [AW-1:0]   ram_wa,
    output logic            ram_we,
    output logic [DW-1:0]   ram_di,
    output logic [AW-1:0]   ram_ra,
    output logic            ram_re,
    input  logic [DW-1:0]   ram_dout,
    output logic [AW+1:0]   fifo_count
);

    localparam logic [AW:0] LP_DEPTH = DEPTH[AW:0];

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_ram_cnt;
    logic          r_inflight;
    logic [1:0]    r_out_cnt;
    logic [DW-1:0] r_buf0;
    logic [DW-1:0] r_buf1;
    logic [AW+1:0] r_fifo_count;

    logic          w_push;
    logic          w_pop;
    logic          w_re;
    logic [2:0]    w_occ;
    logic [AW:0]   w_ram_cnt_nxt;
    logic [1:0]    w_out_cnt_nxt;
    logic [AW+1:0] w_fifo_count_nxt;

    always_comb begin
        wr_prdy          = !reset && (r_ram_cnt < LP_DEPTH);
        rd_pvld          = (r_out_cnt != 2'd0);
        w_push           = wr_pvld & wr_prdy;
        w_pop            = rd_pvld & rd_prdy;
        w_occ            = {1'b0, r_out_cnt} + {2'b00, r_inflight};
        // Issue a read only if the buffer will still have a free slot when the data lands.
        w_re             = (r_ram_cnt != '0) && (w_occ < (3'd2 + {2'b00, w_pop}));
        w_ram_cnt_nxt    = r_ram_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_re};
        w_out_cnt_nxt    = r_out_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
        w_fifo_count_nxt = {1'b0, w_ram_cnt_nxt} + {{(AW+1){1'b0}}, w_re}
                         + {{AW{1'b0}}, w_out_cnt_nxt};
    end

    assign ram_we     = w_push;
    assign ram_wa     = r_wr_ptr;
    assign ram_di     = wr_pd;
    assign ram_re     = w_re;
    assign ram_ra     = r_rd_ptr;
    assign rd_pd      = r_buf0;
    assign fifo_count = r_fifo_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_ram_cnt    <= '0;
            r_inflight   <= 1'b0;
            r_out_cnt    <= 2'd0;
            r_fifo_count <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_re)   r_rd_ptr <= r_rd_ptr + 1'b1;
            r_ram_cnt    <= w_ram_cnt_nxt;
            r_inflight   <= w_re;
            r_out_cnt    <= w_out_cnt_nxt;
            r_fifo_count <= w_fifo_count_nxt;
        end
    end

    // Output buffer: buf0 is the head; captured data fills the first free slot after any pop shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf0 <= '0;
            r_buf1 <= '0;
        end else begin
            case ({r_inflight, w_pop})
                2'b11: begin
                    if (r_out_cnt == 2'd1) begin
                        r_buf0 <= ram_dout;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= ram_dout;
                    end
                end
                2'b01: r_buf0 <= r_buf1;
                2'b10: begin
                    if (r_out_cnt == 2'd0) r_buf0 <= ram_dout;
                    else                   r_buf1 <= ram_dout;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sa_ram_fifo_ctrl_64x64.sv
// Directed bench for sa_ram_fifo_ctrl_64x64 with a behavioural registered-read RAM model.
module tb_sa_ram_fifo_ctrl_64x64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_pvld = 1'b0;
    logic        wr_prdy;
    logic [63:0] wr_pd = '0;
    logic        rd_pvld;
    logic        rd_prdy = 1'b0;
    logic [63:0] rd_pd;
    logic [5:0]  ram_wa;
    logic        ram_we;
    logic [63:0] ram_di;
    logic [5:0]  ram_ra;
    logic        ram_re;
    logic [63:0] ram_dout = '0;
    logic [7:0]  fifo_count;

    logic [63:0] mem [64];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ram_dout <= mem[ram_ra];
    end

    sa_ram_fifo_ctrl_64x64 dut (
        .clk        (clk),
        .reset      (reset),
        .wr_pvld    (wr_pvld),
        .wr_prdy    (wr_prdy),
        .wr_pd      (wr_pd),
        .rd_pvld    (rd_pvld),
        .rd_prdy    (rd_prdy),
        .rd_pd      (rd_pd),
        .ram_wa     (ram_wa),
        .ram_we     (ram_we),
        .ram_di     (ram_di),
        .ram_ra     (ram_ra),
        .ram_re     (ram_re),
        .ram_dout   (ram_dout),
        .fifo_count (fifo_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    // Drive inputs just after an edge, then settle at the falling edge for observation.
    task automatic step(input logic wv, input logic [63:0] wd, input logic rp);
        @(posedge clk);
        #1;
        wr_pvld = wv;
        wr_pd   = wd;
        rd_prdy = rp;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset   = 1'b1;
        wr_pvld = 1'b0;
        rd_prdy = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    int          sent;
    int          rcvd;
    int          bubbles;
    int          first_pop;
    logic [63:0] q[$];
    logic [63:0] exp_d;
    logic        wv;
    logic        rp;

    initial begin
        // Reset state
        #2;
        chk("rst_wr_prdy", {63'd0, wr_prdy}, 64'd0);
        chk("rst_rd_pvld", {63'd0, rd_pvld}, 64'd0);
        chk("rst_count",   {56'd0, fifo_count}, 64'd0);
        chk("rst_rd_pd",   rd_pd, 64'd0);
        do_reset();

        // Test 1: single word latency
        step(1'b1, 64'hA5A5_0000_0000_0001, 1'b1);
        chk("t1_c0_push", {63'd0, wr_prdy}, 64'd1);
        chk("t1_c0_we",   {63'd0, ram_we}, 64'd1);
        chk("t1_c0_pvld", {63'd0, rd_pvld}, 64'd0);
        step(1'b0, 64'd0, 1'b1);
        chk("t1_c1_re",   {63'd0, ram_re}, 64'd1);
        chk("t1_c1_pvld", {63'd0, rd_pvld}, 64'd0);
        chk("t1_c1_cnt",  {56'd0, fifo_count}, 64'd1);
        step(1'b0, 64'd0, 1'b1);
        chk("t1_c2_pvld", {63'd0, rd_pvld}, 64'd0);
        step(1'b0, 64'd0, 1'b1);
        chk("t1_c3_pvld", {63'd0, rd_pvld}, 64'd1);
        chk("t1_c3_data", rd_pd, 64'hA5A5_0000_0000_0001);
        chk("t1_c3_cnt",  {56'd0, fifo_count}, 64'd1);
        step(1'b0, 64'd0, 1'b1);
        chk("t1_c4_pvld", {63'd0, rd_pvld}, 64'd0);
        chk("t1_c4_cnt",  {56'd0, fifo_count}, 64'd0);

        // Test 2: fill with no pops
        do_reset();
        sent = 0;
        for (int i = 0; i < 120; i++) begin
            wv = (sent < 100);
            step(wv, 64'(sent), 1'b0);
            if (wr_pvld && wr_prdy) sent++;
        end
        chk("t2_accepted", 64'(sent), 64'd66);
        chk("t2_wr_prdy",  {63'd0, wr_prdy}, 64'd0);
        chk("t2_count",    {56'd0, fifo_count}, 64'd66);
        chk("t2_rd_pd",    rd_pd, 64'd0);
        chk("t2_rd_pvld",  {63'd0, rd_pvld}, 64'd1);

        // Test 3: single pop from full
        step(1'b1, 64'(sent), 1'b1);
        chk("t3_pop_vld",  {63'd0, rd_pvld}, 64'd1);
        chk("t3_pop_data", rd_pd, 64'd0);
        chk("t3_prdy_t",   {63'd0, wr_prdy}, 64'd0);
        chk("t3_re_t",     {63'd0, ram_re}, 64'd1);
        step(1'b1, 64'(sent), 1'b0);
        chk("t3_prdy_t1",  {63'd0, wr_prdy}, 64'd1);
        if (wr_pvld && wr_prdy) sent++;
        step(1'b1, 64'(sent), 1'b0);
        chk("t3_prdy_t2",  {63'd0, wr_prdy}, 64'd0);
        step(1'b0, 64'd0, 1'b0);
        step(1'b0, 64'd0, 1'b0);
        chk("t3_accepted", 64'(sent), 64'd67);
        chk("t3_count",    {56'd0, fifo_count}, 64'd66);
        chk("t3_head",     rd_pd, 64'd1);

        // Test 4: streaming
        do_reset();
        sent = 0; rcvd = 0; bubbles = 0; first_pop = -1;
        for (int c = 0; c < 1200 && rcvd < 1000; c++) begin
            step(sent < 1000, 64'(sent), 1'b1);
            if (wr_pvld && wr_prdy) sent++;
            if (rd_pvld && rd_prdy) begin
                if (first_pop < 0) first_pop = c;
                chk("t4_data", rd_pd, 64'(rcvd));
                rcvd++;
            end else if (first_pop >= 0) begin
                bubbles++;
            end
        end
        chk("t4_first_pop", 64'(first_pop), 64'd3);
        chk("t4_rcvd",      64'(rcvd), 64'd1000);
        chk("t4_bubbles",   64'(bubbles), 64'd0);
        step(1'b0, 64'd0, 1'b1);
        chk("t4_drained",   {56'd0, fifo_count}, 64'd0);

        // Test 5: random handshakes
        do_reset();
        sent = 0; rcvd = 0;
        q.delete();
        exp_d = {$urandom, $urandom};
        for (int c = 0; c < 5000 && rcvd < 300; c++) begin
            wv = (sent < 300) && ($urandom_range(0, 1) == 1);
            rp = ($urandom_range(0, 1) == 1);
            step(wv, exp_d, rp);
            if (wr_pvld && wr_prdy) begin
                q.push_back(exp_d);
                sent++;
                exp_d = {$urandom, $urandom};
            end
            if (rd_pvld && rd_prdy) begin
                if (q.size() == 0) chk("t5_underflow", rd_pd, 64'hDEAD);
                else chk("t5_data", rd_pd, q.pop_front());
                rcvd++;
            end
        end
        chk("t5_rcvd",  64'(rcvd), 64'd300);
        chk("t5_left",  64'(q.size()), 64'd0);

        // Test 6: reset mid-stream
        do_reset();
        for (int i = 0; i < 40; i++) step(1'b1, 64'(i + 1000), 1'b0);
        step(1'b0, 64'd0, 1'b0);
        step(1'b0, 64'd0, 1'b0);
        chk("t6_count40", {56'd0, fifo_count}, 64'd40);
        step(1'b1, 64'd5000, 1'b1);
        chk("t6_pre_re",   {63'd0, ram_re}, 64'd1);
        chk("t6_pre_pvld", {63'd0, rd_pvld}, 64'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_rst_pvld", {63'd0, rd_pvld}, 64'd0);
        chk("t6_rst_prdy", {63'd0, wr_prdy}, 64'd0);
        chk("t6_rst_we",   {63'd0, ram_we}, 64'd0);
        chk("t6_rst_re",   {63'd0, ram_re}, 64'd0);
        chk("t6_rst_cnt",  {56'd0, fifo_count}, 64'd0);
        wr_pvld = 1'b0;
        rd_prdy = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 64'h1234, 1'b1);
        chk("t6_push", {63'd0, wr_prdy}, 64'd1);
        rcvd = 0;
        for (int c = 0; c < 20 && rcvd == 0; c++) begin
            step(1'b0, 64'd0, 1'b1);
            if (rd_pvld) begin
                chk("t6_first", rd_pd, 64'h1234);
                rcvd = 1;
            end
        end
        chk("t6_got", 64'(rcvd), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
